frame_buffer_scanout: RTL and testbench

//   Downstream consumer of image_streaming_controller. Reads the 2-bytes-per-pixel image from a

---
 rtl/frame_buffer_scanout.sv | 154 +++++++++++++++
 tb/tb_frame_buffer_scanout.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_scanout.sv
// Scans a double-buffered 2-byte-per-pixel image out as RGB565 over valid/ready.
// The back bank is swapped in only at a frame boundary, so a frame never mixes banks.
module frame_buffer_scanout #(
  parameter int unsigned IMAGE_BUF_X = 4,
  parameter int unsigned IMAGE_BUF_Y = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swap,
  output logic [31:0] back_base,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        front_bank
);

  localparam int unsigned IMAGE_BUF_SIZE = IMAGE_BUF_X * IMAGE_BUF_Y * 2;
  localparam int unsigned PIX_N          = IMAGE_BUF_X * IMAGE_BUF_Y;
  localparam int unsigned PX_W           = (PIX_N > 1) ? $clog2(PIX_N) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    CAPTURE  = 3'd3,
    PRESENT  = 3'd4
  } state_t;

  state_t          state_q;
  logic [PX_W-1:0] px_q;
  logic [PX_W-1:0] px_d;
  logic            front_q;
  logic            front_d;
  logic            swap_pending_q;
  logic            have_frame_q;
  logic            rd_en_q;
  logic [31:0]     rd_addr_q;
  logic [31:0]     back_base_q;
  logic [15:0]     pix_data_q;
  logic            pix_valid_q;
  logic            pix_sof_q;
  logic            pix_eol_q;

  logic            transfer;
  logic            last_px;
  logic            boundary;
  logic            apply_swap;
  logic [31:0]     base_d;
  logic [31:0]     hi_addr_d;
  logic            sof_c;
  logic            eol_c;

  // Swap/boundary decode and the address of the next high-byte fetch.
  always_comb begin
    transfer   = (state_q == PRESENT) && pix_valid_q && pix_ready;
    last_px    = (px_q == PX_W'(PIX_N - 1));
    boundary   = (state_q == IDLE) || (transfer && last_px);
    apply_swap = boundary && (swap_pending_q || swap);
    front_d    = front_q ^ apply_swap;
    px_d       = px_q;
    if (state_q == IDLE) begin
      px_d = '0;
    end else if (transfer) begin
      px_d = last_px ? '0 : px_q + PX_W'(1);
    end
    base_d    = front_d ? 32'(IMAGE_BUF_SIZE) : 32'd0;
    hi_addr_d = base_d + (32'(px_d) << 1);
    sof_c     = (px_q == '0);
    eol_c     = ((32'(px_q) % 32'(IMAGE_BUF_X)) == 32'(IMAGE_BUF_X - 1));
  end

  // Scan FSM with registered memory strobe and pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      px_q           <= '0;
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      have_frame_q   <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= 32'd0;
      back_base_q    <= 32'(IMAGE_BUF_SIZE);
      pix_data_q     <= 16'd0;
      pix_valid_q    <= 1'b0;
      pix_sof_q      <= 1'b0;
      pix_eol_q      <= 1'b0;
    end else begin
      swap_pending_q <= apply_swap ? 1'b0 : (swap_pending_q | swap);
      front_q        <= front_d;
      back_base_q    <= front_d ? 32'd0 : 32'(IMAGE_BUF_SIZE);
      case (state_q)
        IDLE: begin
          rd_en_q     <= 1'b0;
          pix_valid_q <= 1'b0;
          pix_sof_q   <= 1'b0;
          pix_eol_q   <= 1'b0;
          if (apply_swap || have_frame_q) begin
            have_frame_q <= 1'b1;
            px_q         <= px_d;
            rd_en_q      <= 1'b1;
            rd_addr_q    <= hi_addr_d;
            state_q      <= FETCH_HI;
          end
        end
        FETCH_HI: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= rd_addr_q + 32'd1;
          state_q   <= FETCH_LO;
        end
        FETCH_LO: begin
          pix_data_q[15:8] <= rd_data;
          rd_en_q          <= 1'b0;
          state_q          <= CAPTURE;
        end
        CAPTURE: begin
          pix_data_q[7:0] <= rd_data;
          pix_valid_q     <= 1'b1;
          pix_sof_q       <= sof_c;
          pix_eol_q       <= eol_c;
          state_q         <= PRESENT;
        end
        PRESENT: begin
          if (transfer) begin
            pix_valid_q <= 1'b0;
            pix_sof_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
            px_q        <= px_d;
            rd_en_q     <= 1'b1;
            rd_addr_q   <= hi_addr_d;
            state_q     <= FETCH_HI;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign back_base  = back_base_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign pix_sof    = pix_sof_q;
  assign pix_eol    = pix_eol_q;
  assign front_bank = front_q;

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Directed bench for frame_buffer_scanout with a 1-cycle-latency byte memory.
module tb_frame_buffer_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic        swap;
  logic [31:0] back_base;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        front_bank;

  logic [7:0]  mem [0:47];
  int          total = 0;
  int          bad = 0;

  frame_buffer_scanout #(.IMAGE_BUF_X(4), .IMAGE_BUF_Y(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .swap       (swap),
    .back_base  (back_base),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .front_bank (front_bank)
  );

  always #5 clk = ~clk;

  // Byte memory: data for the strobed address appears the following cycle.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[5:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bank 1 byte k holds 24+k, bank 0 byte k holds 128+k.
  function automatic logic [15:0] exp_pix(input int bank, input int i);
    int b;
    b = (bank != 0) ? 24 : 128;
    return {8'(b + 2 * i), 8'(b + 2 * i + 1)};
  endfunction

  task automatic wait_valid();
    for (int n = 0; n < 20; n++) begin
      if (pix_valid) return;
      step();
    end
    chk("valid_timeout", 32'(pix_valid), 32'd1);
  endtask

  // Consume one frame; optional stall, swap pulses on given pixels, early stop.
  task automatic run_frame(input int bank, input int stall_at, input int swap_a,
                           input int swap_b, input int stop_at);
    int v;
    for (int i = 0; i < 12; i++) begin
      wait_valid();
      chk($sformatf("pix_data[%0d]", i), 32'(pix_data), 32'(exp_pix(bank, i)));
      chk($sformatf("pix_sof[%0d]", i), 32'(pix_sof), 32'(i == 0));
      chk($sformatf("pix_eol[%0d]", i), 32'(pix_eol), 32'((i % 4) == 3));
      chk($sformatf("front_bank[%0d]", i), 32'(front_bank), 32'(bank));
      if (i == stop_at) return;
      if (i == stall_at) begin
        pix_ready = 1'b0;
        v = 0;
        for (int n = 0; n < 10; n++) begin
          step();
          if (pix_valid !== 1'b1 || pix_data !== exp_pix(bank, i) ||
              pix_sof !== 1'b0 || pix_eol !== 1'b0 || rd_en !== 1'b0) v++;
        end
        chk("stall_hold", 32'(v), 32'd0);
        pix_ready = 1'b1;
      end
      if (i == swap_a || i == swap_b) swap = 1'b1;
      step();
      swap = 1'b0;
      if (i < 11) begin
        chk($sformatf("rd_en_next[%0d]", i), 32'(rd_en), 32'd1);
        chk($sformatf("rd_addr_next[%0d]", i), rd_addr, 32'(bank * 24 + 2 * (i + 1)));
      end
    end
  endtask

  initial begin
    int v;
    for (int k = 0; k < 24; k++) begin
      mem[k]      = 8'(128 + k);
      mem[24 + k] = 8'(24 + k);
    end
    reset = 1'b1;
    swap = 1'b0;
    pix_ready = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset values
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_sof_eol", 32'({pix_sof, pix_eol}), 32'd0);
    chk("rst_front", 32'(front_bank), 32'd0);
    chk("rst_back_base", back_base, 32'd24);

    // No frame before the first swap
    v = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (pix_valid !== 1'b0 || rd_en !== 1'b0) v++;
    end
    chk("idle_quiet", 32'(v), 32'd0);
    chk("idle_front", 32'(front_bank), 32'd0);
    chk("idle_back_base", back_base, 32'd24);

    // First swap: FETCH_HI entered at once, pixel valid three cycles later
    swap = 1'b1;
    step();
    swap = 1'b0;
    chk("swap1_front", 32'(front_bank), 32'd1);
    chk("swap1_back_base", back_base, 32'd0);
    chk("swap1_rd_en", 32'(rd_en), 32'd1);
    chk("swap1_rd_addr", rd_addr, 32'd24);
    step();
    chk("fetch_lo_addr", rd_addr, 32'd25);
    step();
    chk("latency_2", 32'(pix_valid), 32'd0);
    chk("capture_rd_en", 32'(rd_en), 32'd0);
    step();
    chk("latency_3", 32'(pix_valid), 32'd1);

    // Frame from bank 1 with a stall on pixel 5 and a swap on pixel 6
    run_frame(1, 5, 6, -1, -1);
    chk("fa_front", 32'(front_bank), 32'd0);
    chk("fa_back_base", back_base, 32'd24);
    chk("fa_rd_en", 32'(rd_en), 32'd1);
    chk("fa_rd_addr", rd_addr, 32'd0);
    step();
    chk("fa_rd_addr_lo", rd_addr, 32'd1);

    // Bank 0 frame with two swap pulses: one toggle at the boundary
    run_frame(0, -1, 2, 8, -1);
    chk("fb_front", 32'(front_bank), 32'd1);
    chk("fb_back_base", back_base, 32'd0);
    chk("fb_rd_addr", rd_addr, 32'd24);

    // No swap: bank 1 repeats
    run_frame(1, -1, -1, -1, -1);
    chk("fc_front", 32'(front_bank), 32'd1);
    chk("fc_rd_addr", rd_addr, 32'd24);

    // Swap coincident with the last-pixel transfer
    run_frame(1, -1, 11, -1, -1);
    chk("fd_front", 32'(front_bank), 32'd0);
    chk("fd_back_base", back_base, 32'd24);
    chk("fd_rd_addr", rd_addr, 32'd0);

    run_frame(0, -1, 3, -1, -1);
    chk("fe_front", 32'(front_bank), 32'd1);

    // Reset while presenting pixel 7 of a bank-1 frame
    run_frame(1, -1, -1, -1, 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_pix_valid", 32'(pix_valid), 32'd0);
    chk("mrst_rd_en", 32'(rd_en), 32'd0);
    chk("mrst_rd_addr", rd_addr, 32'd0);
    chk("mrst_pix_data", 32'(pix_data), 32'd0);
    chk("mrst_sof_eol", 32'({pix_sof, pix_eol}), 32'd0);
    chk("mrst_front", 32'(front_bank), 32'd0);
    chk("mrst_back_base", back_base, 32'd24);
    v = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (pix_valid !== 1'b0 || rd_en !== 1'b0) v++;
    end
    chk("mrst_idle", 32'(v), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
